ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS32 pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its aluop/alusel/operand/destination outputs.
- Computes the logic, shift, arithmetic and HI/LO-move results combinationally. Outputs feed the EX/MEM register.
- Runs DIV/DIVU on a 32-iteration radix-2 restoring divider FSM and holds the pipeline via stallreq until the quotient and remainder are ready.

---
 rtl/ex_stage_pkg.sv | 49 ++++
 rtl/ex_div.sv | 103 ++++++++++
 rtl/ex_stage.sv | 127 ++++++++++++
 tb/tb_ex_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU op/class codes, divider states, reset/write constants.
// No logic, so no latency or backpressure of its own.
package ex_stage_pkg;

    localparam logic RstEnable    = 1'b0;
    localparam logic Write        = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr = 5'b00000;

    typedef enum logic [7:0] {
        EXE_NOP_OP  = 8'b0000_0000,
        EXE_AND_OP  = 8'b0010_0100,
        EXE_OR_OP   = 8'b0010_0101,
        EXE_XOR_OP  = 8'b0010_0110,
        EXE_NOR_OP  = 8'b0010_0111,
        EXE_SLL_OP  = 8'b0111_1100,
        EXE_SRL_OP  = 8'b0000_0010,
        EXE_SRA_OP  = 8'b0000_0011,
        EXE_MFHI_OP = 8'b0001_0000,
        EXE_MTHI_OP = 8'b0001_0001,
        EXE_MFLO_OP = 8'b0001_0010,
        EXE_MTLO_OP = 8'b0001_0011,
        EXE_DIV_OP  = 8'b0001_1010,
        EXE_DIVU_OP = 8'b0001_1011,
        EXE_ADD_OP  = 8'b0010_0000,
        EXE_ADDU_OP = 8'b0010_0001,
        EXE_SUB_OP  = 8'b0010_0010,
        EXE_SUBU_OP = 8'b0010_0011,
        EXE_SLT_OP  = 8'b0010_1010,
        EXE_SLTU_OP = 8'b0010_1011
    } aluop_e;

    typedef enum logic [2:0] {
        ALUSEL_NOP   = 3'b000,
        ALUSEL_LOGIC = 3'b001,
        ALUSEL_SHIFT = 3'b010,
        ALUSEL_MOVE  = 3'b011,
        ALUSEL_ARITH = 3'b100
    } alusel_e;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider: DATA_W steps after the issue cycle, result valid for the one DivEnd cycle.
// No backpressure; annul returns to DivFree on the next edge from any state.
module ex_div
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic                  annul,
    input  logic [DATA_W-1:0]     opdata1,
    input  logic [DATA_W-1:0]     opdata2,
    output logic [2*DATA_W-1:0]   result,
    output logic                  ready
);

    localparam int CNT_W = $clog2(DATA_W);

    div_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quot;
    logic              neg_q;
    logic              neg_r;

    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic [DATA_W:0]   part;
    logic              step_ok;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quot_nxt;

    assign mag1 = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
    assign mag2 = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;

    // The partial remainder needs one extra bit after the shift, before the trial subtract.
    assign part     = {rem, quot[DATA_W-1]};
    assign step_ok  = (part >= {1'b0, divisor});
    assign rem_nxt  = step_ok ? DATA_W'(part - {1'b0, divisor}) : part[DATA_W-1:0];
    assign quot_nxt = {quot[DATA_W-2:0], step_ok};

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state   <= DivFree;
            cnt     <= '0;
            divisor <= '0;
            rem     <= '0;
            quot    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (annul) begin
            state <= DivFree;
        end else begin
            case (state)
                DivFree: begin
                    if (start) begin
                        if (opdata2 == '0) begin
                            state <= DivByZero;
                        end else begin
                            divisor <= mag2;
                            rem     <= '0;
                            quot    <= mag1;
                            cnt     <= '0;
                            neg_q   <= signed_div && (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
                            neg_r   <= signed_div && opdata1[DATA_W-1];
                            state   <= DivOn;
                        end
                    end
                end
                DivOn: begin
                    // Sign fix-up is folded into the last step so DivEnd presents a settled register.
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        rem   <= neg_r ? -rem_nxt : rem_nxt;
                        quot  <= neg_q ? -quot_nxt : quot_nxt;
                        state <= DivEnd;
                    end else begin
                        rem  <= rem_nxt;
                        quot <= quot_nxt;
                        cnt  <= cnt + 1'b1;
                    end
                end
                DivByZero: begin
                    rem   <= '0;
                    quot  <= '0;
                    state <= DivEnd;
                end
                DivEnd: begin
                    state <= DivFree;
                end
                default: begin
                    state <= DivFree;
                end
            endcase
        end
    end

    assign result = {rem, quot};
    assign ready  = (state == DivEnd);

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: zero-latency ALU/shift/move/HI-LO results; DIV/DIVU take 34 cycles.
// Holds the upstream pipeline with stallreq_o while a divide is in flight; flush_i cancels it.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [7:0]            aluop_i,
    input  logic [2:0]            alusel_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     hi_i,
    input  logic [DATA_W-1:0]     lo_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  whilo_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  stallreq_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0]   logic_res, shift_res, move_res, arith_res;
    logic [DATA_W-1:0]   op2_eff, sum;
    logic [SH_W-1:0]     shamt;
    logic                is_sub, is_trap_op, is_div, ov, lt_s, lt_u;
    logic [2*DATA_W-1:0] div_result;
    logic                div_ready;

    assign shamt      = reg1_i[SH_W-1:0];
    assign is_sub     = (aluop_i == EXE_SUB_OP) || (aluop_i == EXE_SUBU_OP);
    assign is_trap_op = (aluop_i == EXE_ADD_OP) || (aluop_i == EXE_SUB_OP);
    assign is_div     = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign op2_eff    = is_sub ? -reg2_i : reg2_i;
    assign sum        = reg1_i + op2_eff;
    assign ov         = (reg1_i[DATA_W-1] == op2_eff[DATA_W-1]) && (sum[DATA_W-1] != reg1_i[DATA_W-1]);
    assign lt_s       = $signed(reg1_i) < $signed(reg2_i);
    assign lt_u       = reg1_i < reg2_i;

    ex_div #(.DATA_W(DATA_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (is_div),
        .signed_div (aluop_i == EXE_DIV_OP),
        .annul      (flush_i),
        .opdata1    (reg1_i),
        .opdata2    (reg2_i),
        .result     (div_result),
        .ready      (div_ready)
    );

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        move_res  = '0;
        arith_res = '0;
        case (aluop_i)
            EXE_AND_OP:  logic_res = reg1_i & reg2_i;
            EXE_OR_OP:   logic_res = reg1_i | reg2_i;
            EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
            EXE_SLL_OP:  shift_res = reg2_i << shamt;
            EXE_SRL_OP:  shift_res = reg2_i >> shamt;
            EXE_SRA_OP:  shift_res = DATA_W'($signed(reg2_i) >>> shamt);
            EXE_MFHI_OP: move_res  = hi_i;
            EXE_MFLO_OP: move_res  = lo_i;
            EXE_ADD_OP, EXE_ADDU_OP, EXE_SUB_OP, EXE_SUBU_OP: arith_res = sum;
            EXE_SLT_OP:  arith_res = DATA_W'(lt_s);
            EXE_SLTU_OP: arith_res = DATA_W'(lt_u);
            default: ;
        endcase
    end

    always_comb begin
        wd_o       = wd_i;
        wreg_o     = (is_trap_op && ov) ? WriteDisable : wreg_i;
        whilo_o    = WriteDisable;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = is_div && !flush_i && !div_ready;
        case (alusel_i)
            ALUSEL_LOGIC: wdata_o = logic_res;
            ALUSEL_SHIFT: wdata_o = shift_res;
            ALUSEL_MOVE:  wdata_o = move_res;
            ALUSEL_ARITH: wdata_o = arith_res;
            default:      wdata_o = '0;
        endcase
        case (aluop_i)
            EXE_MTHI_OP: begin
                whilo_o = Write;
                hi_o    = reg1_i;
                lo_o    = lo_i;
            end
            EXE_MTLO_OP: begin
                whilo_o = Write;
                hi_o    = hi_i;
                lo_o    = reg1_i;
            end
            EXE_DIV_OP, EXE_DIVU_OP: begin
                if (div_ready && !flush_i) begin
                    whilo_o = Write;
                    hi_o    = div_result[2*DATA_W-1:DATA_W];
                    lo_o    = div_result[DATA_W-1:0];
                end
            end
            default: ;
        endcase
        if (rst == RstEnable) begin
            wd_o       = NOPRegAddr;
            wreg_o     = WriteDisable;
            wdata_o    = '0;
            whilo_o    = WriteDisable;
            hi_o       = '0;
            lo_o       = '0;
            stallreq_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Randomised and directed bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam int DW = 32;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    exp_t expv;
    logic chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    ex_stage #(.DATA_W(DW), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .hi_i(hi_i), .lo_i(lo_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h (aluop %h)", name, $time, act, req, aluop_i);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wd_o",       32'(wd_o),       32'(expv.wd));
            chk("wreg_o",     32'(wreg_o),     32'(expv.wreg));
            chk("wdata_o",    wdata_o,         expv.wdata);
            chk("whilo_o",    32'(whilo_o),    32'(expv.whilo));
            chk("hi_o",       hi_o,            expv.hi);
            chk("lo_o",       lo_o,            expv.lo);
            chk("stallreq_o", 32'(stallreq_o), 32'(expv.stall));
        end
    end

    function automatic exp_t mk(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                input logic whilo, input logic [31:0] h, input logic [31:0] l, input logic st);
        exp_t e;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.whilo = whilo; e.hi = h; e.lo = l; e.stall = st;
        return e;
    endfunction

    function automatic logic sovf(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic exp_t model_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] h, input logic [31:0] l,
                                       input logic [4:0] wd, input logic wreg);
        exp_t e;
        e = '0;
        e.wd = wd;
        e.wreg = wreg;
        case (op)
            EXE_AND_OP:  e.wdata = a & b;
            EXE_OR_OP:   e.wdata = a | b;
            EXE_XOR_OP:  e.wdata = a ^ b;
            EXE_NOR_OP:  e.wdata = ~(a | b);
            EXE_SLL_OP:  e.wdata = b << a[4:0];
            EXE_SRL_OP:  e.wdata = b >> a[4:0];
            EXE_SRA_OP:  e.wdata = 32'($signed(b) >>> a[4:0]);
            EXE_MFHI_OP: e.wdata = h;
            EXE_MFLO_OP: e.wdata = l;
            EXE_ADDU_OP: e.wdata = a + b;
            EXE_SUBU_OP: e.wdata = a - b;
            EXE_ADD_OP: begin
                e.wdata = a + b;
                if (sovf(a, b)) e.wreg = 1'b0;
            end
            EXE_SUB_OP: begin
                e.wdata = a - b;
                if (sovf(a, 32'(0) - b)) e.wreg = 1'b0;
            end
            EXE_SLT_OP:  e.wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            EXE_SLTU_OP: e.wdata = (a < b) ? 32'd1 : 32'd0;
            EXE_MTHI_OP: begin e.whilo = 1'b1; e.hi = a; e.lo = l; end
            EXE_MTLO_OP: begin e.whilo = 1'b1; e.hi = h; e.lo = a; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic void model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] h, output logic [31:0] l, output int n);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            h = '0; l = '0; n = 2;
        end else begin
            sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
            sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
            q = sa / sb;
            r = sa % sb;
            l = q[31:0];
            h = r[31:0];
            n = DW + 1;
        end
    endfunction

    function automatic logic [10:0] pick_op(input int i);
        case (i)
            0:  return {EXE_AND_OP,  ALUSEL_LOGIC};
            1:  return {EXE_OR_OP,   ALUSEL_LOGIC};
            2:  return {EXE_XOR_OP,  ALUSEL_LOGIC};
            3:  return {EXE_NOR_OP,  ALUSEL_LOGIC};
            4:  return {EXE_SLL_OP,  ALUSEL_SHIFT};
            5:  return {EXE_SRL_OP,  ALUSEL_SHIFT};
            6:  return {EXE_SRA_OP,  ALUSEL_SHIFT};
            7:  return {EXE_MFHI_OP, ALUSEL_MOVE};
            8:  return {EXE_MFLO_OP, ALUSEL_MOVE};
            9:  return {EXE_ADD_OP,  ALUSEL_ARITH};
            10: return {EXE_ADDU_OP, ALUSEL_ARITH};
            11: return {EXE_SUB_OP,  ALUSEL_ARITH};
            12: return {EXE_SUBU_OP, ALUSEL_ARITH};
            13: return {EXE_SLT_OP,  ALUSEL_ARITH};
            14: return {EXE_SLTU_OP, ALUSEL_ARITH};
            15: return {EXE_MTHI_OP, ALUSEL_NOP};
            16: return {EXE_MTLO_OP, ALUSEL_NOP};
            default: return {8'hEE, 3'($urandom_range(0, 4))};
        endcase
    endfunction

    task automatic drive_op(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] wd, input logic wreg);
        @(posedge clk);
        #1;
        rst = 1'b1; flush_i = 1'b0;
        aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wreg;
        hi_i = $urandom; lo_i = $urandom;
        expv = model_alu(op, a, b, hi_i, lo_i, wd, wreg);
    endtask

    // nstall/ehi/elo are supplied by the caller: literals for directed cases, the model otherwise.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int nstall,
                           input logic [31:0] ehi, input logic [31:0] elo, input int flush_at, input int rst_at);
        logic [7:0] op;
        op = sgn ? EXE_DIV_OP : EXE_DIVU_OP;
        for (int c = 0; c <= nstall; c++) begin
            @(posedge clk);
            #1;
            rst = 1'b1; flush_i = (c == flush_at);
            aluop_i = op; alusel_i = ALUSEL_NOP; reg1_i = a; reg2_i = b;
            wd_i = 5'($urandom); wreg_i = 1'b0; hi_i = $urandom; lo_i = $urandom;
            expv = model_alu(op, a, b, hi_i, lo_i, wd_i, 1'b0);
            expv.stall = (c < nstall) && (c != flush_at);
            if (c == nstall) begin
                expv.whilo = 1'b1; expv.hi = ehi; expv.lo = elo;
            end
            if (c == rst_at) begin
                #1 rst = 1'b0;
                expv = '0;
            end
            if (c == flush_at || c == rst_at) break;
        end
    endtask

    initial begin
        logic [31:0] a, b, h, l;
        logic [10:0] os;
        logic        sgn;
        int          n;

        rst = 1'b0; flush_i = 1'b0;
        aluop_i = EXE_OR_OP; alusel_i = ALUSEL_LOGIC;
        reg1_i = $urandom; reg2_i = $urandom; wd_i = 5'd7; wreg_i = 1'b1;
        hi_i = $urandom; lo_i = $urandom;
        expv = '0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);

        drive_op(EXE_OR_OP, ALUSEL_LOGIC, 32'h0000F0F0, 32'h00FF00FF, 5'd3, 1'b1);
        expv = mk(5'd3, 1'b1, 32'h00FFF0FF, 1'b0, 32'h0, 32'h0, 1'b0);
        drive_op(EXE_ADD_OP, ALUSEL_ARITH, 32'h7FFFFFFF, 32'h1, 5'd4, 1'b1);
        expv = mk(5'd4, 1'b0, 32'h80000000, 1'b0, 32'h0, 32'h0, 1'b0);
        drive_op(EXE_ADDU_OP, ALUSEL_ARITH, 32'h7FFFFFFF, 32'h1, 5'd4, 1'b1);
        expv = mk(5'd4, 1'b1, 32'h80000000, 1'b0, 32'h0, 32'h0, 1'b0);
        drive_op(EXE_SUB_OP, ALUSEL_ARITH, 32'h80000000, 32'h1, 5'd6, 1'b1);
        expv = mk(5'd6, 1'b0, 32'h7FFFFFFF, 1'b0, 32'h0, 32'h0, 1'b0);
        drive_op(EXE_SRA_OP, ALUSEL_SHIFT, 32'd4, 32'hF0000000, 5'd5, 1'b1);
        expv = mk(5'd5, 1'b1, 32'hFF000000, 1'b0, 32'h0, 32'h0, 1'b0);
        drive_op(EXE_SLTU_OP, ALUSEL_ARITH, 32'hFFFFFFFF, 32'h1, 5'd8, 1'b1);
        expv = mk(5'd8, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive_op(EXE_SLT_OP, ALUSEL_ARITH, 32'hFFFFFFFF, 32'h1, 5'd8, 1'b1);
        expv = mk(5'd8, 1'b1, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0);
        drive_op(8'hEE, ALUSEL_LOGIC, 32'h12345678, 32'h9ABCDEF0, 5'd9, 1'b1);
        expv = mk(5'd9, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, -1, -1);
        run_div(1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14, -1, -1);
        run_div(1'b0, 32'd55, 32'd0, 2, 32'd0, 32'd0, -1, -1);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000, -1, -1);
        run_div(1'b1, 32'd1000, 32'd3, 33, 32'd1, 32'd333, 10, -1);
        run_div(1'b1, 32'd1000, 32'd3, 33, 32'd1, 32'd333, -1, -1);
        run_div(1'b0, 32'd1000, 32'd3, 33, 32'd1, 32'd333, -1, 20);
        run_div(1'b1, 32'hFFFFFC18, 32'd3, 33, 32'hFFFFFFFF, 32'hFFFFFEB3, -1, -1);

        for (int i = 0; i < 300; i++) begin
            os = pick_op($urandom_range(0, 18));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            drive_op(os[10:3], os[2:0], a, b, 5'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 10; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            b   = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            model_div(sgn, a, b, h, l, n);
            run_div(sgn, a, b, n, h, l, -1, -1);
        end

        @(posedge clk);
        #1 chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
